// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding and
// byte-lane mask construction.
package mem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

   localparam int WORD_BYTES = 4;

   // Expands a per-byte enable into a 32-bit bit mask.
   function automatic logic [8*WORD_BYTES-1:0] lane_mask(input logic [WORD_BYTES-1:0] be);
      logic [8*WORD_BYTES-1:0] mask;
      mask = '0;
      for (int i = 0; i < WORD_BYTES; i++) begin
         mask[8*i +: 8] = {8{be[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/be_ram.sv
// DEPTH x 32 word storage with independent per-byte-lane write enables and a
// combinational read port sharing the write address.
module be_ram
   import mem_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                       clk,
   input  logic [WORD_BYTES-1:0]      we,
   input  logic [$clog2(DEPTH)-1:0]   addr,
   input  logic [8*WORD_BYTES-1:0]    wdata,
   output logic [8*WORD_BYTES-1:0]    rdata
);

   logic [8*WORD_BYTES-1:0] mem [DEPTH];

   // NOTE: storage is deliberately left out of reset; contents must survive
   // a reset and a resettable array would not map onto RAM.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Stallable data-memory responder: latches a request, waits WAIT_STATES
// cycles, then commits a lane-masked write or read and pulses MemReady.
module dmem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemReq,
   input  logic                  MemWrite,
   input  logic [31:0]           Addr,
   input  logic [31:0]           WriteData,
   input  logic [WORD_BYTES-1:0] byteEnable,
   output logic [31:0]           ReadData,
   output logic                  MemReady,
   output logic                  MemError
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   mem_state_t state, state_next;
   logic [3:0] cnt, cnt_next;

   logic [29:0]           lat_word;
   logic [31:0]           lat_wdata;
   logic [WORD_BYTES-1:0] lat_be;
   logic                  lat_write;

   logic [29:0]           cur_word;
   logic [31:0]           cur_wdata;
   logic [WORD_BYTES-1:0] cur_be;
   logic                  cur_write;
   logic                  cur_oor;
   logic                  lat_oor;
   logic                  accept;
   logic                  commit;
   logic [WORD_BYTES-1:0] ram_we;
   logic [31:0]           ram_rdata;

   logic unused_addr_bits;
   assign unused_addr_bits = ^Addr[1:0];

   assign accept = (state == IDLE) && MemReq;

   // In IDLE a zero-wait access commits straight from the inputs; otherwise
   // only the latched request is used.
   always_comb begin
      if (state == IDLE) begin
         cur_word  = Addr[31:2];
         cur_wdata = WriteData;
         cur_be    = byteEnable;
         cur_write = MemWrite;
      end else begin
         cur_word  = lat_word;
         cur_wdata = lat_wdata;
         cur_be    = lat_be;
         cur_write = lat_write;
      end
   end

   assign cur_oor = |cur_word[29:AW];
   assign lat_oor = |lat_word[29:AW];

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      unique case (state)
         IDLE: begin
            if (MemReq) begin
               if (WAIT_STATES == 0) begin
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
                  cnt_next   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_next = RESP;
            else             cnt_next   = cnt - 4'd1;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Work happens on the edge into RESP; reset on that edge cancels it.
   assign commit = (state_next == RESP) && !reset;
   assign ram_we = (commit && cur_write && !cur_oor) ? cur_be : '0;

   be_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (cur_word[AW-1:0]),
      .wdata (cur_wdata),
      .rdata (ram_rdata)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         ReadData <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (commit && !cur_write) begin
            ReadData <= cur_oor ? 32'd0 : (ram_rdata & lane_mask(cur_be));
         end
      end
   end

   // Request latch carries no reset: it is only read after a fresh accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_word  <= Addr[31:2];
         lat_wdata <= WriteData;
         lat_be    <= byteEnable;
         lat_write <= MemWrite;
      end
   end

   assign MemReady = (state == RESP);
   assign MemError = (state == RESP) && lat_oor;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with 2 wait states and
// one with none, checked against a byte-array memory model.
module tb_dmem_responder;

   localparam int DEPTH = 64;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req   [2];
   logic        mem_write [2];
   logic [31:0] addr      [2];
   logic [31:0] wdata     [2];
   logic [3:0]  be        [2];
   logic [31:0] rdata     [2];
   logic        ready     [2];
   logic        err       [2];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   exp_t        sb0[$];
   exp_t        sb1[$];
   logic [7:0]  model_mem [2][DEPTH][4];
   logic [31:0] last_rd   [2];

   dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemReq     (mem_req[0]),
      .MemWrite   (mem_write[0]),
      .Addr       (addr[0]),
      .WriteData  (wdata[0]),
      .byteEnable (be[0]),
      .ReadData   (rdata[0]),
      .MemReady   (ready[0]),
      .MemError   (err[0])
   );

   dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut_ws0 (
      .clk        (clk),
      .reset      (reset),
      .MemReq     (mem_req[1]),
      .MemWrite   (mem_write[1]),
      .Addr       (addr[1]),
      .WriteData  (wdata[1]),
      .byteEnable (be[1]),
      .ReadData   (rdata[1]),
      .MemReady   (ready[1]),
      .MemError   (err[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int ws(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic bit out_of_range(input logic [31:0] a);
      return a >= 32'(4 * DEPTH);
   endfunction

   function automatic logic [31:0] model_read(input int d, input logic [31:0] a, input logic [3:0] b);
      logic [31:0] r;
      r = '0;
      if (!out_of_range(a)) begin
         for (int i = 0; i < 4; i++) begin
            if (b[i]) r[8*i +: 8] = model_mem[d][a / 4][i];
         end
      end
      return r;
   endfunction

   task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b);
      if (!out_of_range(a)) begin
         for (int i = 0; i < 4; i++) begin
            if (b[i]) model_mem[d][a / 4][i] = wd[8*i +: 8];
         end
      end
   endtask

   task automatic push_exp(input int d, input exp_t e);
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   task automatic wait_ready(input int d);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (ready[d]) seen = 1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: dut %0d gave no MemReady within 40 cycles", d);
      end
   endtask

   // One complete request; the expected response is queued at issue time.
   task automatic access(input int d, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b, input bit scramble = 0);
      exp_t e;
      @(posedge clk);
      #1;
      mem_req[d]   = 1'b1;
      mem_write[d] = wr;
      addr[d]      = a;
      wdata[d]     = wd;
      be[d]        = b;
      e.due = cyc + 1 + ws(d);
      e.err = out_of_range(a);
      if (wr) begin
         model_write(d, a, wd, b);
         e.data = last_rd[d];
      end else begin
         e.data     = model_read(d, a, b);
         last_rd[d] = e.data;
      end
      push_exp(d, e);
      if (scramble) begin
         @(posedge clk);
         #1;
         addr[d]  = 32'h30;
         wdata[d] = 32'hFFFF_FFFF;
      end
      wait_ready(d);
      mem_req[d] = 1'b0;
   endtask

   task automatic monitor(input int d);
      exp_t e;
      bit   have;
      if (ready[d] === 1'b1) begin
         have = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
         if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: dut %0d pulsed MemReady at cycle %0d with nothing pending", d, cyc);
         end else begin
            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            check($sformatf("ready_cycle[%0d]", d), 32'(cyc), 32'(e.due));
            check($sformatf("read_data[%0d]", d), rdata[d], e.data);
            check($sformatf("mem_error[%0d]", d), {31'd0, err[d]}, {31'd0, e.err});
         end
      end else begin
         check($sformatf("idle_error[%0d]", d), {31'd0, err[d]}, 32'd0);
      end
   endtask

   always @(negedge clk) begin
      monitor(0);
      monitor(1);
   end

   initial begin
      exp_t e;
      logic [31:0] a;
      int          d;

      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         mem_req[i]   = 1'b0;
         mem_write[i] = 1'b0;
         addr[i]      = '0;
         wdata[i]     = '0;
         be[i]        = '0;
         last_rd[i]   = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("reset_read_data", rdata[i], 32'd0);
         check("reset_ready", {31'd0, ready[i]}, 32'd0);
      end
      reset = 1'b0;

      // Known contents everywhere.
      for (int w = 0; w < DEPTH; w++) access(0, 1, 32'(w * 4), $urandom(), 4'hF);
      for (int w = 0; w < DEPTH; w++) access(1, 1, 32'(w * 4), $urandom(), 4'hF);

      // Full and partial writes with readback.
      access(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      access(0, 0, 32'h10, 32'h0, 4'hF);
      access(0, 1, 32'h10, 32'h0000_AA00, 4'b0010);
      access(0, 0, 32'h10, 32'h0, 4'hF);
      access(0, 0, 32'h10, 32'h0, 4'b0001);
      access(0, 0, 32'h10, 32'h0, 4'b0000);

      // Range check: out-of-range write must leave every word intact.
      access(0, 1, 32'h100, 32'h5555_AAAA, 4'hF);
      for (int w = 0; w < DEPTH; w++) access(0, 0, 32'(w * 4), 32'h0, 4'hF);
      access(0, 0, 32'h100, 32'h0, 4'hF);
      access(0, 0, 32'hFC, 32'h0, 4'hF);

      // Reset in the middle of a write's wait states.
      @(posedge clk);
      #1;
      mem_req[0]   = 1'b1;
      mem_write[0] = 1'b1;
      addr[0]      = 32'h20;
      wdata[0]     = 32'h1234_5678;
      be[0]        = 4'hF;
      @(posedge clk);
      #1;
      reset      = 1'b1;
      mem_req[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midreset_read_data", rdata[0], 32'd0);
      check("midreset_ready", {31'd0, ready[0]}, 32'd0);
      check("midreset_error", {31'd0, err[0]}, 32'd0);
      reset      = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      repeat (5) @(posedge clk);
      access(0, 0, 32'h20, 32'h0, 4'hF);

      // Inputs changed during WAIT must not affect the latched access.
      access(0, 1, 32'h10, 32'hCAFE_F00D, 4'hF, 1);
      access(0, 0, 32'h10, 32'h0, 4'hF);
      access(0, 0, 32'h30, 32'h0, 4'hF);

      // Zero wait states, MemReq held high across three reads.
      @(posedge clk);
      #1;
      mem_req[1]   = 1'b1;
      mem_write[1] = 1'b0;
      be[1]        = 4'hF;
      addr[1]      = 32'h0;
      for (int n = 0; n < 3; n++) begin
         e.due      = cyc + 1 + 2 * n;
         e.err      = 1'b0;
         e.data     = model_read(1, 32'(n * 4), 4'hF);
         last_rd[1] = e.data;
         sb1.push_back(e);
      end
      for (int n = 0; n < 3; n++) begin
         wait_ready(1);
         addr[1] = 32'((n + 1) * 4);
      end
      mem_req[1] = 1'b0;

      // Randomised traffic on both instances.
      for (int n = 0; n < 80; n++) begin
         d = (n % 4 == 0) ? 1 : 0;
         case ($urandom_range(0, 9))
            0:       a = 32'h100 + 32'($urandom_range(0, 63) * 4);
            1:       a = $urandom();
            default: a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
         endcase
         access(d, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)));
      end

      repeat (10) @(negedge clk);
      check("pending_responses", 32'(sb0.size() + sb1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
